// File: rtl/handshake_ack_responder.sv
// Downstream responder for a req/ack handshake: captures the payload on the rising edge of req and
// answers with a one-cycle ack after a programmable 1-3 cycle delay.
module handshake_ack_responder #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OVR_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [DATA_W-1:0] req_data,
  input  logic [1:0]        delay_cfg,
  output logic              ack,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic [OVR_W-1:0]  ovr_cnt,
  output logic              cfg_err
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StAck  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] payload_q, payload_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              ack_q, ack_d;
  logic [OVR_W-1:0]  ovr_q, ovr_d;
  logic              cfg_err_q, cfg_err_d;
  logic              req_q;
  logic              req_rise;

  assign req_rise = req & ~req_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    payload_d  = payload_q;
    rsp_data_d = rsp_data_q;
    ack_d      = 1'b0;
    ovr_d      = ovr_q;
    cfg_err_d  = cfg_err_q;

    unique case (state_q)
      StIdle: begin
        if (req_rise) begin
          payload_d = req_data;
          state_d   = StWait;
          // A zero delay would break the ack window, so it is promoted to one and flagged.
          if (delay_cfg == 2'd0) begin
            cnt_d     = 2'd1;
            cfg_err_d = 1'b1;
          end else begin
            cnt_d = delay_cfg;
          end
        end
      end
      StWait: begin
        if (cnt_q == 2'd1) begin
          ack_d      = 1'b1;
          rsp_data_d = payload_q;
          state_d    = StAck;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Rising edges seen while a transaction is in flight are dropped and counted.
    if (req_rise && (state_q != StIdle) && (ovr_q != {OVR_W{1'b1}})) begin
      ovr_d = ovr_q + OVR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 2'd0;
      payload_q  <= '0;
      rsp_data_q <= '0;
      ack_q      <= 1'b0;
      ovr_q      <= '0;
      cfg_err_q  <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      payload_q  <= payload_d;
      rsp_data_q <= rsp_data_d;
      ack_q      <= ack_d;
      ovr_q      <= ovr_d;
      cfg_err_q  <= cfg_err_d;
      req_q      <= req;
    end
  end

  assign ack       = ack_q;
  assign rsp_valid = ack_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q == StWait) || (state_q == StAck);
  assign ovr_cnt   = ovr_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_handshake_ack_responder.sv
// Scoreboard bench for handshake_ack_responder: an edge-indexed reference model predicts ack timing,
// payloads, busy windows and counters; a negedge monitor compares the DUT against it.
module tb_handshake_ack_responder;

  localparam int DATA_W  = 8;
  localparam int OVR_W   = 4;
  localparam int OVR_MAX = (1 << OVR_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req;
  logic [DATA_W-1:0] req_data;
  logic [1:0]        delay_cfg;
  logic              ack;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;
  logic [OVR_W-1:0]  ovr_cnt;
  logic              cfg_err;

  handshake_ack_responder #(
    .DATA_W(DATA_W),
    .OVR_W (OVR_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .delay_cfg(delay_cfg),
    .ack      (ack),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .busy     (busy),
    .ovr_cnt  (ovr_cnt),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                at;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  // Reference model state, indexed by posedge number.
  bit                req_prev = 1'b0;
  int                next_ok  = 0;
  int                b_lo     = -10;
  int                b_hi     = -10;
  bit                pend     = 1'b0;
  int                ack_at   = 0;
  logic [DATA_W-1:0] pend_data;
  logic [DATA_W-1:0] m_rsp    = '0;
  int                m_ovr    = 0;
  bit                m_cfg    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    int   d;
    exp_t e;
    cyc++;
    if (!rst_n) begin
      sb.delete();
      pend     = 1'b0;
      m_rsp    = '0;
      m_ovr    = 0;
      m_cfg    = 1'b0;
      next_ok  = 0;
      req_prev = 1'b0;
      b_lo     = -10;
      b_hi     = -10;
    end else begin
      if (pend && cyc == ack_at) begin
        m_rsp = pend_data;
        pend  = 1'b0;
      end
      if (req && !req_prev) begin
        if (cyc >= next_ok) begin
          d = (delay_cfg == 2'd0) ? 1 : int'(delay_cfg);
          if (delay_cfg == 2'd0) m_cfg = 1'b1;
          ack_at    = cyc + d;
          pend      = 1'b1;
          pend_data = req_data;
          e.at      = ack_at;
          e.data    = req_data;
          sb.push_back(e);
          b_lo      = cyc;
          b_hi      = cyc + d;
          next_ok   = cyc + d + 2;
        end else if (m_ovr < OVR_MAX) begin
          m_ovr++;
        end
      end
      req_prev = req;
    end
  end

  always @(negedge clk) begin
    bit exp_ack;
    if (mon_en) begin
      exp_ack = (sb.size() > 0) && (sb[0].at == cyc);
      chk("ack", 32'(ack), 32'(exp_ack));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_ack));
      if (exp_ack) begin
        chk("rsp_data_at_ack", 32'(rsp_data), 32'(sb[0].data));
        void'(sb.pop_front());
      end
      chk("rsp_data", 32'(rsp_data), 32'(m_rsp));
      chk("busy", 32'(busy), 32'((cyc >= b_lo) && (cyc <= b_hi)));
      chk("ovr_cnt", 32'(ovr_cnt), 32'(m_ovr));
      chk("cfg_err", 32'(cfg_err), 32'(m_cfg));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse(input logic [DATA_W-1:0] dat, input logic [1:0] cfg, input int wait_n);
    req       = 1'b1;
    req_data  = dat;
    delay_cfg = cfg;
    tick();
    req = 1'b0;
    repeat (wait_n) tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = 1'b0;
    req_data  = '0;
    delay_cfg = 2'd1;
    repeat (2) tick();
    mon_en = 1'b1;
    rst_n  = 1'b1;
    tick();

    pulse(8'hA5, 2'd1, 5);
    pulse(8'h11, 2'd2, 6);
    pulse(8'h22, 2'd3, 6);
    pulse(8'h44, 2'd1, 5);

    pulse(8'h33, 2'd0, 5);
    pulse(8'h55, 2'd2, 6);
    chk("cfg_err_sticky", 32'(cfg_err), 32'd1);

    // Two extra rises during the wait; the late delay_cfg change must not matter.
    req = 1'b1; req_data = 8'h66; delay_cfg = 2'd3; tick();
    req = 1'b0; req_data = 8'h99; delay_cfg = 2'd1; tick();
    req = 1'b1; tick();
    req = 1'b0; tick();
    req = 1'b1; tick();
    req = 1'b0;
    repeat (6) tick();
    chk("ovr_two", 32'(ovr_cnt), 32'd2);
    chk("rsp_first_payload", 32'(rsp_data), 32'h66);

    delay_cfg = 2'd3;
    for (int i = 0; i < 80; i++) begin
      req      = ~req;
      req_data = DATA_W'($urandom);
      tick();
    end
    req = 1'b0;
    repeat (6) tick();
    chk("ovr_saturated", 32'(ovr_cnt), 32'(OVR_MAX));

    req = 1'b1; req_data = 8'h77; delay_cfg = 2'd3; tick();
    req = 1'b0; tick();
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("ovr_after_reset", 32'(ovr_cnt), 32'd0);
    pulse(8'h88, 2'd1, 4);
    chk("rsp_after_reset", 32'(rsp_data), 32'h88);

    for (int i = 0; i < 400; i++) begin
      req       = ($urandom_range(0, 99) < 40);
      req_data  = DATA_W'($urandom);
      delay_cfg = 2'($urandom_range(0, 3));
      rst_n     = ($urandom_range(0, 99) >= 2);
      tick();
    end
    rst_n = 1'b1;
    req   = 1'b0;
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
